axis_testpattern_checker: RTL and testbench

AXI-Stream slave that consumes the counter stream produced by `axis_testpattern_generator` and verifies it on the fly. It locks onto the incoming sequence and checks every accepted beat against the expected next value (same START/END/INCR wrap rules as the generator), counting beats and errors. It can optionally apply a programmable backpressure pattern on `s_axis_tready` to stress the upstream handshake. It sits directly downstream of the generator, either in loopback test builds or at the far end of a datapath under test.

---
 rtl/axis_testpattern_checker.sv | 156 +++++++++++++++
 tb/tb_axis_testpattern_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_testpattern_checker.sv
// AXI-Stream checker for the counter test pattern: locks onto the stream and counts beats/mismatches.
// Optional tready throttling is enabled with `define AXIS_TP_CHECKER_READY_THROTTLE_EN.
module axis_testpattern_checker #(
  parameter int unsigned S00_AXIS_TDATA_WIDTH = 24,
  parameter int unsigned COUNTER_START        = 1,
  parameter int unsigned COUNTER_END          = 10,
  parameter int unsigned COUNTER_INCR         = 1,
  parameter logic [7:0]  READY_PATTERN        = 8'b1111_0110
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            enable,
  input  logic                            clear,
  input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic                            locked,
  output logic                            error_pulse,
  output logic [15:0]                     error_count,
  output logic [31:0]                     beat_count
);

  localparam int unsigned W  = S00_AXIS_TDATA_WIDTH;
  localparam int unsigned WX = W + 1;

  localparam logic [WX-1:0] C_START = WX'(COUNTER_START);
  localparam logic [WX-1:0] C_END   = WX'(COUNTER_END);
  localparam logic [WX-1:0] C_INCR  = WX'(COUNTER_INCR);

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_expected;
  logic [W-1:0]  w_expected_nxt;
  logic          r_tready;
  logic          r_locked;
  logic          w_locked_nxt;
  logic          r_error_pulse;
  logic          w_error_pulse_nxt;
  logic [15:0]   r_error_count;
  logic [15:0]   w_error_count_nxt;
  logic [31:0]   r_beat_count;
  logic [31:0]   w_beat_count_nxt;
  logic          w_accept;
  logic          w_in_range;
  logic [W-1:0]  w_data_next;

  // Sequence successor with wrap, evaluated one bit wider so the sum cannot overflow.
  function automatic logic [W-1:0] f_next(input logic [W-1:0] x);
    logic [WX-1:0] sum;
    logic [W-1:0]  res;
    sum = {1'b0, x} + C_INCR;
    res = sum[W-1:0];
    if (sum > C_END) begin
      res = C_START[W-1:0];
    end
    return res;
  endfunction

  assign w_accept    = s_axis_tvalid && r_tready;
  assign w_in_range  = ({1'b0, s_axis_tdata} >= C_START) && ({1'b0, s_axis_tdata} <= C_END);
  assign w_data_next = f_next(s_axis_tdata);

  // State register and registered outputs.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_state       <= S_HUNT;
      r_expected    <= C_START[W-1:0];
      r_locked      <= 1'b0;
      r_error_pulse <= 1'b0;
      r_error_count <= 16'd0;
      r_beat_count  <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_expected    <= w_expected_nxt;
      r_locked      <= w_locked_nxt;
      r_error_pulse <= w_error_pulse_nxt;
      r_error_count <= w_error_count_nxt;
      r_beat_count  <= w_beat_count_nxt;
    end
  end

  // Next-state and counter logic; clear outranks a coincident beat.
  always_comb begin
    w_state_nxt       = r_state;
    w_expected_nxt    = r_expected;
    w_error_pulse_nxt = 1'b0;
    w_error_count_nxt = r_error_count;
    w_beat_count_nxt  = r_beat_count;
    if (clear) begin
      w_state_nxt       = S_HUNT;
      w_error_count_nxt = 16'd0;
      w_beat_count_nxt  = 32'd0;
    end else if (w_accept) begin
      w_beat_count_nxt = r_beat_count + 32'd1;
      case (r_state)
        S_HUNT: begin
          if (w_in_range) begin
            w_expected_nxt = w_data_next;
            w_state_nxt    = S_LOCKED;
          end
        end
        S_LOCKED: begin
          w_expected_nxt = w_data_next;
          if (s_axis_tdata != r_expected) begin
            w_error_pulse_nxt = 1'b1;
            if (r_error_count != 16'hFFFF) begin
              w_error_count_nxt = r_error_count + 16'd1;
            end
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
    w_locked_nxt = (w_state_nxt == S_LOCKED);
  end

`ifdef AXIS_TP_CHECKER_READY_THROTTLE_EN
  logic [2:0] r_ptr;

  // Rotating ready mask; the pointer only moves while enabled so pauses keep the phase.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_ptr    <= 3'd0;
      r_tready <= 1'b0;
    end else begin
      r_tready <= enable && READY_PATTERN[r_ptr];
      if (enable) begin
        r_ptr <= r_ptr + 3'd1;
      end
    end
  end
`else
  logic w_unused_pattern;
  assign w_unused_pattern = ^READY_PATTERN;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= enable;
    end
  end
`endif

  assign s_axis_tready = r_tready;
  assign locked        = r_locked;
  assign error_pulse   = r_error_pulse;
  assign error_count   = r_error_count;
  assign beat_count    = r_beat_count;

endmodule

// File: tb/tb_axis_testpattern_checker.sv
// Directed bench for axis_testpattern_checker (default parameters, 1..10 step 1).
// The throttle section is selected by AXIS_TP_CHECKER_READY_THROTTLE_EN.
module tb_axis_testpattern_checker;

  logic        clk;
  logic        areset;
  logic        en;
  logic        clr;
  logic [23:0] td;
  logic        tv;
  logic        tready;
  logic        lck;
  logic        epulse;
  logic [15:0] ecnt;
  logic [31:0] bcnt;

  int n_cmp;
  int n_bad;
  logic [23:0] v;

  axis_testpattern_checker dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (areset),
    .enable        (en),
    .clear         (clr),
    .s_axis_tdata  (td),
    .s_axis_tvalid (tv),
    .s_axis_tready (tready),
    .locked        (lck),
    .error_pulse   (epulse),
    .error_count   (ecnt),
    .beat_count    (bcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] nextv(input logic [23:0] x);
    return (x + 24'd1 > 24'd10) ? 24'd1 : x + 24'd1;
  endfunction

`ifdef AXIS_TP_CHECKER_READY_THROTTLE_EN
  logic [7:0] pat;
  logic [2:0] b_ptr;
  logic       b_rdy;
  int         n_acc;

  // One clock with a small tready model; data advances only on accepted beats.
  task automatic tcycle();
    logic acc;
    acc = tv && b_rdy;
    tick();
    b_rdy = en ? pat[b_ptr] : 1'b0;
    if (en) b_ptr = b_ptr + 3'd1;
    if (acc) begin
      chk("thr_pulse", 32'(epulse), 32'd0);
      v = nextv(v);
      n_acc++;
      td = v;
    end
    chk("thr_tready", 32'(tready), 32'(b_rdy));
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    areset = 1'b1;
    en     = 1'b1;
    clr    = 1'b0;
    tv     = 1'b0;
    td     = 24'd0;
    v      = 24'd1;
    tick();
    tick();
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_locked", 32'(lck), 32'd0);
    chk("rst_pulse", 32'(epulse), 32'd0);
    chk("rst_ecnt", 32'(ecnt), 32'd0);
    chk("rst_bcnt", bcnt, 32'd0);

`ifdef AXIS_TP_CHECKER_READY_THROTTLE_EN
    pat   = 8'b1111_0110;
    b_ptr = 3'd0;
    b_rdy = 1'b0;
    n_acc = 0;
    areset = 1'b0;
    tcycle();
    tv = 1'b1;
    td = v;
    for (int i = 0; i < 16; i++) tcycle();
    chk("thr_bcnt16", bcnt, 32'd12);
    chk("thr_locked", 32'(lck), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) tcycle();
    chk("thr_pause_bcnt", bcnt, 32'd12);
    en = 1'b1;
    for (int i = 0; i < 8; i++) tcycle();
    chk("thr_resume_bcnt", bcnt, 32'(n_acc));
    chk("thr_ecnt", 32'(ecnt), 32'd0);
`else
    areset = 1'b0;
    tick();
    chk("ready_after_rst", 32'(tready), 32'd1);

    // 100 beats of 1..10 including the 10->1 wraps
    tv = 1'b1;
    for (int i = 0; i < 100; i++) begin
      td = v;
      tick();
      chk("run_pulse", 32'(epulse), 32'd0);
      if (i == 0) chk("run_lock_first", 32'(lck), 32'd1);
      v = nextv(v);
    end
    chk("run_ecnt", 32'(ecnt), 32'd0);
    chk("run_bcnt", bcnt, 32'd100);
    chk("run_locked", 32'(lck), 32'd1);

    // 1,2,3,7,8,9: one error on 7 then resync
    begin
      logic [23:0] inj [6];
      logic        ep  [6];
      inj = '{24'd1, 24'd2, 24'd3, 24'd7, 24'd8, 24'd9};
      ep  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
        td = inj[i];
        tick();
        chk("inj_pulse", 32'(epulse), 32'(ep[i]));
      end
    end
    chk("inj_ecnt", 32'(ecnt), 32'd1);
    chk("inj_bcnt", bcnt, 32'd106);

    tv  = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ecnt", 32'(ecnt), 32'd0);
    chk("clr_bcnt", bcnt, 32'd0);
    chk("clr_locked", 32'(lck), 32'd0);

    // HUNT drops out-of-range 15, locks on 3
    tv = 1'b1;
    td = 24'd15; tick();
    chk("hunt_oor_locked", 32'(lck), 32'd0);
    chk("hunt_oor_pulse", 32'(epulse), 32'd0);
    td = 24'd3; tick();
    chk("hunt_lock3", 32'(lck), 32'd1);
    td = 24'd4; tick();
    td = 24'd5; tick();
    chk("hunt_ecnt", 32'(ecnt), 32'd0);
    chk("hunt_bcnt", bcnt, 32'd4);

    // two consecutive mismatches (expected 6 then 10)
    td = 24'd9; tick();
    chk("b2b_pulse1", 32'(epulse), 32'd1);
    td = 24'd3; tick();
    chk("b2b_pulse2", 32'(epulse), 32'd1);
    chk("b2b_ecnt", 32'(ecnt), 32'd2);

    // clear coincident with a beat of 5
    td  = 24'd5;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrbeat_ecnt", 32'(ecnt), 32'd0);
    chk("clrbeat_bcnt", bcnt, 32'd0);
    chk("clrbeat_locked", 32'(lck), 32'd0);
    chk("clrbeat_pulse", 32'(epulse), 32'd0);
    td = 24'd6; tick();
    chk("relock_locked", 32'(lck), 32'd1);
    chk("relock_bcnt", bcnt, 32'd1);
    chk("relock_pulse", 32'(epulse), 32'd0);
    td = 24'd7; tick();
    chk("relock_next_pulse", 32'(epulse), 32'd0);
    td = 24'd1; tick();
    chk("pre_rst_pulse", 32'(epulse), 32'd1);

    // reset mid-stream for one cycle
    areset = 1'b1;
    td = 24'd8;
    tick();
    chk("mid_rst_tready", 32'(tready), 32'd0);
    chk("mid_rst_locked", 32'(lck), 32'd0);
    chk("mid_rst_pulse", 32'(epulse), 32'd0);
    chk("mid_rst_ecnt", 32'(ecnt), 32'd0);
    chk("mid_rst_bcnt", bcnt, 32'd0);
    areset = 1'b0;
    tv = 1'b0;
    tick();
    chk("mid_rst_ready2", 32'(tready), 32'd1);
    tv = 1'b1;
    td = 24'd8; tick();
    chk("post_rst_locked", 32'(lck), 32'd1);
    chk("post_rst_pulse", 32'(epulse), 32'd0);
    chk("post_rst_bcnt", bcnt, 32'd1);
    td = 24'd9; tick();
    chk("post_rst_pulse2", 32'(epulse), 32'd0);

    // enable low for 5 cycles, sequence resumes at 10
    en = 1'b0;
    tv = 1'b0;
    tick();
    chk("pause_tready0", 32'(tready), 32'd0);
    tv = 1'b1;
    td = 24'd10;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pause_tready", 32'(tready), 32'd0);
      chk("pause_bcnt", bcnt, 32'd2);
    end
    en = 1'b1;
    tick();
    chk("resume_tready", 32'(tready), 32'd1);
    chk("resume_bcnt0", bcnt, 32'd2);
    tick();
    chk("resume_pulse10", 32'(epulse), 32'd0);
    chk("resume_bcnt1", bcnt, 32'd3);
    td = 24'd1; tick();
    chk("resume_pulse1", 32'(epulse), 32'd0);
    chk("resume_bcnt2", bcnt, 32'd4);
    chk("resume_ecnt", 32'(ecnt), 32'd0);
    chk("resume_locked", 32'(lck), 32'd1);
    tv = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
